push_conditioner: RTL and testbench

- Multi-channel push-button conditioner for the tug-of-war datapath; one channel per player button.
- Each channel is a 2-flop synchroniser, a debounce FSM and a one-pulse generator.
- Optional features: auto-repeat while held, and release-edge pulses.
- Outputs feed round/score logic. A simultaneous-press flag lets referee logic resolve ties.

---
 rtl/push_conditioner_if.sv | 27 ++
 rtl/push_conditioner.sv | 133 +++++++++++++
 tb/tb_push_conditioner.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/push_conditioner_if.sv
// push_conditioner_if: button inputs, enable and conditioned outputs.
// master drives push/en, slave is the conditioner.
interface push_conditioner_if #(
  parameter int CHANNELS = 2
);
  logic                en;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] level;
  logic                simul;

  modport master (
    output en,
    output push,
    input  pulse,
    input  level,
    input  simul
  );

  modport slave (
    input  en,
    input  push,
    output pulse,
    output level,
    output simul
  );
endinterface

// File: rtl/push_conditioner.sv
// push_conditioner: per-channel 2-flop sync, debounce FSM and one-pulse.
// Optional auto-repeat while held and release-edge pulses.
module push_conditioner #(
  parameter int CHANNELS        = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8,
  parameter int EDGE_MODE       = 0
) (
  input logic               clk,
  input logic               rst,
  push_conditioner_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = (HMAX < 2) ? 1 : $clog2(HMAX);

  localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] RD_LAST =
    (REPEAT_DELAY > 0) ? HW'(REPEAT_DELAY - 1) : '0;
  localparam logic [HW-1:0] RP_LAST = HW'(REPEAT_PERIOD - 1);
  localparam bit PRESS_ON = (EDGE_MODE != 1);
  localparam bit REL_ON   = (EDGE_MODE != 0);
  localparam bit RPT_ON   = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] per;
  logic [CHANNELS-1:0] fire;
  logic [CHANNELS-1:0] ev;
  logic [CHANNELS-1:0] nxt_pulse;

  state_t        st [CHANNELS];
  logic [DW-1:0] dc [CHANNELS];
  logic [HW-1:0] hc [CHANNELS];

  // per=0 counts toward the first repeat, per=1 toward later ones
  always_comb begin
    fire = '0;
    ev   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fire[c] = RPT_ON && s2[c] &&
        (per[c] ? (hc[c] == RP_LAST) : (hc[c] == RD_LAST));
      unique case (st[c])
        DB_PRESS:
          ev[c] = PRESS_ON && s2[c] && (dc[c] == DC_LAST);
        HELD:
          ev[c] = PRESS_ON && fire[c];
        DB_RELEASE:
          ev[c] = REL_ON && !s2[c] && (dc[c] == DC_LAST);
        default:
          ev[c] = 1'b0;
      endcase
    end
  end

  assign nxt_pulse = bus.en ? ev : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1        <= '0;
      s2        <= '0;
      per       <= '0;
      bus.pulse <= '0;
      bus.level <= '0;
      bus.simul <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        st[c] <= IDLE;
        dc[c] <= '0;
        hc[c] <= '0;
      end
    end else begin
      s1        <= bus.push;
      s2        <= s1;
      bus.pulse <= nxt_pulse;
      bus.simul <= ($countones(nxt_pulse) > 1);
      for (int c = 0; c < CHANNELS; c++) begin
        unique case (st[c])
          IDLE: begin
            if (s2[c]) begin
              st[c] <= DB_PRESS;
              dc[c] <= DW'(1);
            end
          end
          DB_PRESS: begin
            if (!s2[c]) begin
              st[c] <= IDLE;
              dc[c] <= '0;
            end else if (dc[c] == DC_LAST) begin
              st[c]        <= HELD;
              bus.level[c] <= 1'b1;
              hc[c]        <= '0;
              per[c]       <= 1'b0;
            end else begin
              dc[c] <= dc[c] + DW'(1);
            end
          end
          HELD: begin
            if (!s2[c]) begin
              st[c] <= DB_RELEASE;
              dc[c] <= DW'(1);
            end else if (fire[c]) begin
              hc[c]  <= '0;
              per[c] <= 1'b1;
            end else begin
              hc[c] <= hc[c] + HW'(1);
            end
          end
          DB_RELEASE: begin
            if (s2[c]) begin
              st[c] <= HELD;
            end else if (dc[c] == DC_LAST) begin
              st[c]        <= IDLE;
              bus.level[c] <= 1'b0;
              dc[c]        <= '0;
            end else begin
              dc[c] <= dc[c] + DW'(1);
            end
          end
          default: st[c] <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_push_conditioner.sv
// tb_push_conditioner: three configurations driven in parallel and
// compared each cycle against a sample-window reference model.
module tb_push_conditioner;
  localparam int CH = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CH-1:0] push;

  always #5 clk = ~clk;

  push_conditioner_if #(.CHANNELS(CH)) b0 ();
  push_conditioner_if #(.CHANNELS(CH)) b1 ();
  push_conditioner_if #(.CHANNELS(CH)) b2 ();

  assign b0.push = push;
  assign b0.en   = en;
  assign b1.push = push;
  assign b1.en   = en;
  assign b2.push = push;
  assign b2.en   = en;

  push_conditioner #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(8), .EDGE_MODE(0)
  ) u0 (.clk(clk), .rst(rst), .bus(b0.slave));

  push_conditioner #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .EDGE_MODE(0)
  ) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  push_conditioner #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(8), .EDGE_MODE(2)
  ) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int fp0 = -1;
  int cnt [3][CH];
  int simcnt [3];

  logic [CH-1:0] ms1, ms2, mlvl;
  logic [DB-1:0] hist [CH];
  int            mj [3][CH];
  logic [CH-1:0] mp [3];
  logic          ms [3];

  function automatic int rdv(int i);
    return (i == 1) ? 10 : 0;
  endfunction

  function automatic int rpv(int i);
    return (i == 1) ? 5 : 8;
  endfunction

  function automatic int emv(int i);
    return (i == 2) ? 2 : 0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Level flips once the last DB synchronised samples all disagree with it;
  // repeats fire at fixed offsets counted over held-high edges.
  task automatic model_edge();
    logic [DB-1:0] nh;
    logic flip, press, rel, held, fire, ev;
    int rd, rp, em;
    if (!rst) begin
      ms1  = '0;
      ms2  = '0;
      mlvl = '0;
      for (int c = 0; c < CH; c++) hist[c] = '0;
      for (int i = 0; i < 3; i++) begin
        mp[i] = '0;
        ms[i] = 1'b0;
        for (int c = 0; c < CH; c++) mj[i][c] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) mp[i] = '0;
      for (int c = 0; c < CH; c++) begin
        nh    = {hist[c][DB-2:0], ms2[c]};
        flip  = mlvl[c] ? (nh == '0) : (nh == '1);
        press = flip && !mlvl[c];
        rel   = flip && mlvl[c];
        held  = mlvl[c] && ms2[c] && hist[c][0];
        for (int i = 0; i < 3; i++) begin
          rd   = rdv(i);
          rp   = rpv(i);
          em   = emv(i);
          fire = 1'b0;
          if (held) begin
            if (rd > 0 && mj[i][c] >= rd - 1 &&
                (mj[i][c] - (rd - 1)) % rp == 0)
              fire = 1'b1;
            mj[i][c]++;
          end
          if (press) mj[i][c] = 0;
          ev = ((press || fire) && em != 1) || (rel && em != 0);
          mp[i][c] = ev && en;
        end
        hist[c] = nh;
        if (flip) mlvl[c] = !mlvl[c];
      end
      for (int i = 0; i < 3; i++) ms[i] = ($countones(mp[i]) >= 2);
      ms2 = ms1;
      ms1 = push;
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] op [3];
    logic [CH-1:0] ol [3];
    logic          os [3];
    op[0] = b0.pulse; ol[0] = b0.level; os[0] = b0.simul;
    op[1] = b1.pulse; ol[1] = b1.level; os[1] = b1.simul;
    op[2] = b2.pulse; ol[2] = b2.level; os[2] = b2.simul;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.pulse@%0d", i, edge_n), 32'(op[i]), 32'(mp[i]));
      check($sformatf("u%0d.level@%0d", i, edge_n), 32'(ol[i]), 32'(mlvl));
      check($sformatf("u%0d.simul@%0d", i, edge_n), 32'(os[i]), 32'(ms[i]));
      for (int c = 0; c < CH; c++) cnt[i][c] += int'(op[i][c]);
      simcnt[i] += int'(os[i]);
    end
    if (fp0 < 0 && op[0][0]) fp0 = edge_n;
  endtask

  task automatic step(input logic [CH-1:0] p, input logic e, input logic r);
    push = p;
    en   = e;
    rst  = r;
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic clear_counts();
    fp0 = -1;
    for (int i = 0; i < 3; i++) begin
      simcnt[i] = 0;
      for (int c = 0; c < CH; c++) cnt[i][c] = 0;
    end
  endtask

  initial begin
    int k;
    int len;
    logic [CH-1:0] p;
    logic e;
    logic [5:0] bounce;
    push = '0;
    en   = 1'b1;
    rst  = 1'b0;
    clear_counts();
    repeat (3) step(2'b00, 1'b1, 1'b0);
    check("reset.level", 32'(b0.level), 32'h0);
    check("reset.pulse", 32'(b1.pulse), 32'h0);
    repeat (4) step(2'b00, 1'b1, 1'b1);

    // clean press
    clear_counts();
    k = edge_n + 1;
    repeat (12) step(2'b01, 1'b1, 1'b1);
    check("t1.latency", 32'(fp0 - k), 32'd5);
    check("t1.cnt0", 32'(cnt[0][0]), 32'd1);
    check("t1.cnt1", 32'(cnt[0][1]), 32'd0);
    check("t1.simul", 32'(simcnt[0]), 32'd0);
    repeat (10) step(2'b00, 1'b1, 1'b1);

    // bounce rejection then a clean 6-cycle press
    clear_counts();
    bounce = 6'b011011;
    for (int i = 0; i < 6; i++) step({1'b0, bounce[i]}, 1'b1, 1'b1);
    repeat (8) step(2'b00, 1'b1, 1'b1);
    check("t2.bounce", 32'(cnt[0][0]), 32'd0);
    repeat (6) step(2'b01, 1'b1, 1'b1);
    repeat (10) step(2'b00, 1'b1, 1'b1);
    check("t2.press", 32'(cnt[0][0]), 32'd1);

    // auto-repeat on channel 1
    clear_counts();
    repeat (40) step(2'b10, 1'b1, 1'b1);
    repeat (15) step(2'b00, 1'b1, 1'b1);
    check("t3.repeat", 32'(cnt[1][1]), 32'd7);
    check("t3.norpt", 32'(cnt[0][1]), 32'd1);
    check("t3.both", 32'(cnt[2][1]), 32'd2);

    // press and release, both-edge mode
    clear_counts();
    repeat (8) step(2'b01, 1'b1, 1'b1);
    repeat (12) step(2'b00, 1'b1, 1'b1);
    check("t4.both", 32'(cnt[2][0]), 32'd2);
    check("t4.press", 32'(cnt[0][0]), 32'd1);

    // simultaneous press, then enable gating
    clear_counts();
    repeat (8) step(2'b11, 1'b1, 1'b1);
    check("t5.simul", 32'(simcnt[0]), 32'd1);
    repeat (12) step(2'b00, 1'b1, 1'b1);
    clear_counts();
    repeat (8) step(2'b11, 1'b0, 1'b1);
    check("t5.level", 32'(b0.level), 32'h3);
    check("t5.gated", 32'(cnt[0][0] + cnt[0][1]), 32'd0);
    check("t5.gsimul", 32'(simcnt[0]), 32'd0);
    repeat (4) step(2'b11, 1'b1, 1'b1);
    check("t5.late", 32'(cnt[0][0] + cnt[0][1]), 32'd0);
    repeat (12) step(2'b00, 1'b1, 1'b1);

    // reset mid-debounce
    repeat (4) step(2'b01, 1'b1, 1'b1);
    repeat (3) step(2'b01, 1'b1, 1'b0);
    check("t6.rlevel", 32'(b0.level), 32'h0);
    check("t6.rpulse", 32'(b0.pulse), 32'h0);
    clear_counts();
    k = edge_n + 1;
    repeat (9) step(2'b01, 1'b1, 1'b1);
    check("t6.latency", 32'(fp0 - k), 32'd5);
    check("t6.cnt", 32'(cnt[0][0]), 32'd1);
    repeat (10) step(2'b00, 1'b1, 1'b1);

    // randomized segments
    for (int s = 0; s < 300; s++) begin
      p   = CH'($urandom);
      e   = ($urandom % 8) != 0;
      len = ($urandom % 6 == 0) ? $urandom_range(20, 45)
                                : $urandom_range(1, 8);
      for (int t = 0; t < len; t++)
        step(p, e, ($urandom % 60) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
